// File: rtl/seven_segment_mux.sv
// Time-multiplexed N-digit BCD seven-segment driver.
// Loads are double-buffered and applied only at frame boundaries, so a scan frame
// never shows a mix of old and new digits. Each digit slot opens with GUARD dark
// clocks to suppress ghosting while the digit drivers switch.

// Per-digit decode with leading-zero blanking; purely combinational.
module seven_segment_digit #(
  parameter bit IS_LSD = 1'b0      // the least significant digit is never blanked
) (
  input  logic [3:0] bcd,
  input  logic       upper_zero,   // every more significant digit is zero
  input  logic       blank_en,
  output logic [6:0] seg           // {g,f,e,d,c,b,a}, active high
);

  logic blank;

  // Blank a zero only when every digit above it is also zero.
  always_comb begin
    blank = 1'b0;
    if (!IS_LSD && blank_en && upper_zero && (bcd == 4'd0)) blank = 1'b1;
  end

  // BCD to segments; codes 10..15 show a dash so bad data is visible.
  always_comb begin
    seg = 7'b1000000;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = 7'b0111111;
        4'd1:    seg = 7'b0000110;
        4'd2:    seg = 7'b1011011;
        4'd3:    seg = 7'b1001111;
        4'd4:    seg = 7'b1100110;
        4'd5:    seg = 7'b1101101;
        4'd6:    seg = 7'b1111101;
        4'd7:    seg = 7'b0000111;
        4'd8:    seg = 7'b1111111;
        4'd9:    seg = 7'b1101111;
        default: seg = 7'b1000000;
      endcase
    end else begin
      seg = 7'b0000000;
    end
  end

endmodule

module seven_segment_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int GUARD          = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_en,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_GUARD = PRE_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

  // One captured display image: digit i of bcd maps to bcd_in[4i+3:4i].
  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] bcd;
    logic [NUM_DIGITS-1:0]      dp;
  } frame_t;

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  frame_t                pend_q, pend_d;
  frame_t                disp_q, disp_d;
  logic                  pending_q, pending_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  frame_t                     load_frame;
  logic                       wrap;
  logic                       boundary;
  logic [NUM_DIGITS-1:0]      upper_zero;
  logic [NUM_DIGITS-1:0][6:0] dig_seg;

  // Pack the flat input bus into a frame image.
  always_comb begin
    load_frame     = '0;
    load_frame.bcd = bcd_in;
    load_frame.dp  = dp_in;
  end

  // Prescaler and scan index; a boundary is the wrap out of the last digit slot.
  always_comb begin
    wrap         = (pre_q == PRE_LAST);
    boundary     = wrap && (idx_q == IDX_LAST);
    pre_d        = wrap ? '0 : pre_q + 1'b1;
    idx_d        = idx_q;
    if (wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    frame_tick_d = boundary;
  end

  // Double buffer: loads park in pend until the frame boundary, except a load
  // landing exactly on the boundary, which goes straight to the display.
  always_comb begin
    pend_d    = pend_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (load && boundary) begin
      disp_d    = load_frame;
      pending_d = 1'b0;
    end else begin
      if (boundary && pending_q) begin
        disp_d    = pend_q;
        pending_d = 1'b0;
      end
      if (load) begin
        pend_d    = load_frame;
        pending_d = 1'b1;
      end
    end
  end

  // Per-digit decoders; each sees whether all digits above it are zero.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    if (i == NUM_DIGITS - 1) begin : g_top
      assign upper_zero[i] = 1'b1;
    end else begin : g_lower
      assign upper_zero[i] = ~|disp_q.bcd[NUM_DIGITS-1:i+1];
    end
    seven_segment_digit #(.IS_LSD(i == 0)) u_dig (
      .bcd        (disp_q.bcd[i]),
      .upper_zero (upper_zero[i]),
      .blank_en   (blank_en),
      .seg        (dig_seg[i])
    );
  end

  // Output stage: dark during the guard window, else one digit on; polarity last.
  always_comb begin
    dig_d = '0;
    seg_d = '0;
    dp_d  = 1'b0;
    if (pre_q >= PRE_GUARD) begin
      dig_d[idx_q] = 1'b1;
      seg_d        = dig_seg[idx_q];
      dp_d         = disp_q.dp[idx_q];
    end
    dig_d = dig_d ^ {NUM_DIGITS{DIG_INV}};
    seg_d = seg_d ^ {7{SEG_INV}};
    dp_d  = dp_d ^ SEG_INV;
  end

  // State and output registers; reset drives outputs to their inactive level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= {7{SEG_INV}};
      dp_q         <= SEG_INV;
      dig_q        <= {NUM_DIGITS{DIG_INV}};
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_q        <= dig_d;
    end
  end

  assign segments   = seg_q;
  assign dp         = dp_q;
  assign digit_en   = dig_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Scoreboard bench: an active-high and an active-low instance share stimulus.
// The driver predicts each cycle's outputs from a cycle-count model and queues
// them; the monitor pops and compares one cycle later.
module tb_seven_segment_mux;
  localparam int N = 4, DIV = 8, GUARD = 2;

  logic clk = 1'b0, reset_n = 1'b0, load = 1'b0, blank_en = 1'b0;
  logic [4*N-1:0] bcd_in = '0;
  logic [N-1:0]   dp_in = '0;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1, ft0, ft1;
  logic [N-1:0] den0, den1;

  always #5 clk = ~clk;

  seven_segment_mux #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD(GUARD),
                      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank_en(blank_en), .segments(seg0), .dp(dp0), .digit_en(den0), .frame_tick(ft0));

  seven_segment_mux #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD(GUARD),
                      .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .blank_en(blank_en), .segments(seg1), .dp(dp1), .digit_en(den1), .frame_tick(ft1));

  typedef struct { logic [N-1:0] den; logic [6:0] seg; logic dp; logic ft; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_cmp = 0, n_err = 0;

  // reference model state
  int cyc;
  int disp[N], pend[N];
  bit ddp[N], pdp[N];
  bit pending;

  function automatic logic [6:0] lut(int v);
    case (v)
      0: return 7'b0111111;  1: return 7'b0000110;  2: return 7'b1011011;
      3: return 7'b1001111;  4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;  8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0; pending = 0;
    for (int i = 0; i < N; i++) begin disp[i] = 0; pend[i] = 0; ddp[i] = 0; pdp[i] = 0; end
  endtask

  // Predict the outputs after the coming edge, update the model, advance one clock.
  task automatic step();
    exp_t e;
    int pre, idx;
    bit bnd, blk;
    pre = cyc % DIV;
    idx = (cyc / DIV) % N;
    e.den = '0; e.seg = '0; e.dp = 1'b0;
    if (pre >= GUARD) begin
      e.den = N'(1 << idx);
      blk = blank_en && (idx > 0);
      for (int j = idx; j < N; j++) if (disp[j] != 0) blk = 0;
      e.seg = blk ? 7'b0 : lut(disp[idx]);
      e.dp  = ddp[idx];
    end
    bnd  = (pre == DIV - 1) && (idx == N - 1);
    e.ft = bnd;
    q.push_back(e);
    if (load && bnd) begin
      for (int i = 0; i < N; i++) begin disp[i] = int'(bcd_in[4*i +: 4]); ddp[i] = dp_in[i]; end
      pending = 0;
    end else begin
      if (bnd && pending) begin
        for (int i = 0; i < N; i++) begin disp[i] = pend[i]; ddp[i] = pdp[i]; end
        pending = 0;
      end
      if (load) begin
        for (int i = 0; i < N; i++) begin pend[i] = int'(bcd_in[4*i +: 4]); pdp[i] = dp_in[i]; end
        pending = 1;
      end
    end
    cyc++;
    @(posedge clk);
    #2;
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic go_to(input int p, input int i);
    while (!((cyc % DIV == p) && ((cyc / DIV) % N == i))) step();
  endtask

  task automatic do_load(input logic [4*N-1:0] b, input logic [N-1:0] d);
    bcd_in = b; dp_in = d; load = 1'b1;
    step();
  endtask

  task automatic check_idle(input string tag);
    check({tag, " dut0 idle"}, {20'b0, den0, seg0, dp0, ft0}, 32'h0);
    check({tag, " dut1 idle"}, {20'b0, den1, seg1, dp1, ft1}, {20'b0, {N{1'b1}}, 7'h7f, 1'b1, 1'b0});
  endtask

  // Monitor: compare each queued prediction against both instances.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("dut0 {den,seg,dp,ft}", {20'b0, den0, seg0, dp0, ft0},
            {20'b0, mon_e.den, mon_e.seg, mon_e.dp, mon_e.ft});
      check("dut1 {den,seg,dp,ft}", {20'b0, den1, seg1, dp1, ft1},
            {20'b0, ~mon_e.den, ~mon_e.seg, ~mon_e.dp, mon_e.ft});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_idle("reset");
    reset_n = 1'b1;

    // scan with blank display, then directed cases
    run(40);
    go_to(3, 1);
    do_load(16'h1234, 4'b0000);
    run(70);
    blank_en = 1'b1;
    do_load(16'h0070, 4'b1000);
    run(70);
    blank_en = 1'b0;
    run(40);
    do_load(16'h0C00, 4'b0100);
    run(70);
    // pending load superseded by a load exactly on the boundary
    go_to(4, 0);
    do_load(16'h1111, 4'b1111);
    go_to(DIV - 1, N - 1);
    do_load(16'h9876, 4'b0101);
    run(70);

    // randomized stretch
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        load = 1'b1;
        for (int i = 0; i < N; i++)
          bcd_in[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
        dp_in = N'($urandom);
      end
      if ($urandom_range(0, 15) == 0) blank_en = ~blank_en;
      step();
    end

    // asynchronous reset in mid-slot
    run($urandom_range(3, 20));
    #1;
    reset_n = 1'b0;
    q.delete();
    #1;
    check_idle("async reset");
    repeat (2) @(posedge clk);
    #2;
    check_idle("held reset");
    model_reset();
    reset_n = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        load = 1'b1;
        bcd_in = 16'($urandom);
        dp_in = N'($urandom);
      end
      blank_en = ($urandom_range(0, 3) != 0);
      step();
    end

    for (int k = 0; k < 5 && q.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    check("scoreboard drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
